knn_vote: RTL and testbench

- Consumer stage of the KNN pipeline, downstream of distance_sort.
- Captures the sorted distance/type arrays on valid_sort and runs a majority vote over the K nearest entries.
- Reports the winning class, its vote count and the nearest distance, with a one-cycle done pulse.
- Feeds the classifier result register/top-level FSM.

---
 rtl/knn_vote.sv | 148 ++++++++++++++
 tb/tb_knn_vote.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_vote.sv
// KNN majority vote: captures the sorted distance/type arrays on a valid_sort
// rising edge, counts the K nearest labels, then scans the classes for the winner.

module knn_vote_cnt #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end
endmodule

module knn_vote #(
  parameter int L      = 5,
  parameter int W      = 32,
  parameter int TYPE_W = 3,
  parameter int K      = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_sort,
  input  logic [W*(1<<L)-1:0]        distance_array_sorted,
  input  logic [TYPE_W*(1<<L)-1:0]   type_array_sorted,
  output logic [TYPE_W-1:0]          class_type,
  output logic [L:0]                 class_votes,
  output logic [W-1:0]               nearest_distance,
  output logic                       busy,
  output logic                       done_class
);
  localparam int N     = 1 << L;
  localparam int T     = 1 << TYPE_W;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  if (K < 1 || K > N) begin : g_bad_k
    $error("knn_vote: K must satisfy 1 <= K <= N");
  end

  typedef enum logic [1:0] {IDLE, COUNT, SELECT} state_t;
  state_t state, state_nxt;

  logic                     valid_q;
  logic                     start;
  logic [K-1:0][TYPE_W-1:0] types_q;
  logic [IDX_W-1:0]         idx;
  logic [TYPE_W-1:0]        cls, best_cls, sel_cls;
  logic [L:0]               best_cnt, sel_cnt;
  logic [T-1:0][L:0]        cnt;
  logic                     last_idx, last_cls;
  logic                     unused_ok;

  // Only entry 0 of distances and entries 0..K-1 of types matter.
  assign unused_ok = ^{distance_array_sorted, type_array_sorted};

  assign start    = valid_sort & ~valid_q;
  assign last_idx = (idx == IDX_W'(K-1));
  assign last_cls = (cls == {TYPE_W{1'b1}});

  for (genvar c = 0; c < T; c++) begin : g_cnt
    knn_vote_cnt #(.CW(L+1)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr ((state == IDLE) && start),
      .inc ((state == COUNT) && (types_q[idx] == TYPE_W'(c))),
      .cnt (cnt[c])
    );
  end

  // Strict greater-than keeps the lowest class index on ties.
  always_comb begin
    sel_cls = best_cls;
    sel_cnt = best_cnt;
    if (cls == '0) begin
      sel_cls = '0;
      sel_cnt = cnt[0];
    end else if (cnt[cls] > best_cnt) begin
      sel_cls = cls;
      sel_cnt = cnt[cls];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = COUNT;
      COUNT:   if (last_idx) state_nxt = SELECT;
      SELECT:  if (last_cls) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q          <= 1'b0;
      types_q          <= '0;
      idx              <= '0;
      cls              <= '0;
      best_cls         <= '0;
      best_cnt         <= '0;
      class_type       <= '0;
      class_votes      <= '0;
      nearest_distance <= '0;
      busy             <= 1'b0;
      done_class       <= 1'b0;
    end else begin
      valid_q    <= valid_sort;
      done_class <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < K; i++)
              types_q[i] <= type_array_sorted[i*TYPE_W +: TYPE_W];
            nearest_distance <= distance_array_sorted[W-1:0];
            idx              <= '0;
            busy             <= 1'b1;
          end
        end
        COUNT: begin
          idx <= idx + 1'b1;
          if (last_idx) cls <= '0;
        end
        SELECT: begin
          best_cls <= sel_cls;
          best_cnt <= sel_cnt;
          cls      <= cls + 1'b1;
          if (last_cls) begin
            class_type  <= sel_cls;
            class_votes <= sel_cnt;
            done_class  <= 1'b1;
            busy        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_knn_vote.sv
// Self-checking bench for knn_vote: directed scenarios plus random votes
// checked against a counting reference model.
module tb_knn_vote;
  localparam int L = 5, W = 32, TYPE_W = 3, K = 5;
  localparam int N = 1 << L, T = 1 << TYPE_W, LAT = K + T;

  logic                   clk = 0, rst = 0, valid_sort = 0;
  logic [W*N-1:0]         distance_array_sorted = '0;
  logic [TYPE_W*N-1:0]    type_array_sorted = '0;
  logic [TYPE_W-1:0]      class_type;
  logic [L:0]             class_votes;
  logic [W-1:0]           nearest_distance;
  logic                   busy, done_class;

  int errors = 0, checks = 0;
  int tv[N];
  logic [W-1:0] dv[N];

  knn_vote #(.L(L), .W(W), .TYPE_W(TYPE_W), .K(K)) dut (
    .clk(clk), .rst(rst), .valid_sort(valid_sort),
    .distance_array_sorted(distance_array_sorted),
    .type_array_sorted(type_array_sorted),
    .class_type(class_type), .class_votes(class_votes),
    .nearest_distance(nearest_distance), .busy(busy), .done_class(done_class)
  );

  always #5 clk = ~clk;

  task automatic load_arrays();
    for (int i = 0; i < N; i++) begin
      distance_array_sorted[i*W +: W] = dv[i];
      type_array_sorted[i*TYPE_W +: TYPE_W] = TYPE_W'(tv[i]);
    end
  endtask

  task automatic rand_arrays();
    logic [W-1:0] d;
    d = W'($urandom_range(0, 5000));
    for (int i = 0; i < N; i++) begin
      tv[i] = $urandom_range(0, T-1);
      dv[i] = d;
      d = d + W'($urandom_range(0, 300));
    end
    load_arrays();
  endtask

  // Reference: tally the K nearest labels, take the highest tally, and
  // report the smallest label achieving it.
  function automatic void model(output int ec, output int ev);
    int tally[T];
    for (int c = 0; c < T; c++) tally[c] = 0;
    for (int i = 0; i < K; i++) tally[tv[i]]++;
    ev = 0;
    for (int c = 0; c < T; c++) if (tally[c] > ev) ev = tally[c];
    ec = -1;
    for (int c = T-1; c >= 0; c--) if (tally[c] == ev) ec = c;
  endfunction

  // Leaves the caller just after start edge E.
  task automatic start_pulse();
    @(posedge clk); #1 valid_sort = 1;
    @(posedge clk); #1 valid_sort = 0;
  endtask

  // Returns cycles after E at which done_class is seen (-1 on timeout).
  task automatic wait_done(output int lat, output int busy_bad);
    lat = -1; busy_bad = (busy !== 1'b1) ? 1 : 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done_class === 1'b1) begin lat = n; break; end
      if (busy !== 1'b1) busy_bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1; #12; rst = 0;
    @(posedge clk); #1;
    checks++; if ({class_type, class_votes} !== '0) begin errors++;
      $display("FAIL reset_class got %0d/%0d want 0/0", class_type, class_votes); end
    checks++; if (nearest_distance !== '0) begin errors++;
      $display("FAIL reset_nearest got %0d want 0", nearest_distance); end
    checks++; if (busy !== 1'b0 || done_class !== 1'b0) begin errors++;
      $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done_class); end
  endtask

  task automatic test_single_class();
    int lat, bb;
    for (int i = 0; i < N; i++) begin tv[i] = 2; dv[i] = W'(7 + i); end
    load_arrays();
    start_pulse();
    wait_done(lat, bb);
    checks++; if (lat != LAT) begin errors++;
      $display("FAIL single_latency got %0d want %0d", lat, LAT); end
    checks++; if (bb != 0) begin errors++;
      $display("FAIL single_busy low cycles=%0d want 0", bb); end
    checks++; if (class_type !== 3'd2 || class_votes !== 6'd5) begin errors++;
      $display("FAIL single_result got %0d/%0d want 2/5", class_type, class_votes); end
    checks++; if (nearest_distance !== 32'd7) begin errors++;
      $display("FAIL single_nearest got %0d want 7", nearest_distance); end
    @(posedge clk); #1;
    checks++; if (done_class !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL single_pulse done=%b busy=%b want 0 0", done_class, busy); end
  endtask

  task automatic test_pattern(input string name, input int a0, input int a1,
                              input int a2, input int a3, input int a4,
                              input int wc, input int wv);
    int lat, bb;
    for (int i = 0; i < N; i++) begin tv[i] = 5; dv[i] = W'(100 + i); end
    tv[0] = a0; tv[1] = a1; tv[2] = a2; tv[3] = a3; tv[4] = a4;
    load_arrays();
    start_pulse();
    wait_done(lat, bb);
    checks++;
    if (lat != LAT || int'(class_type) != wc || int'(class_votes) != wv) begin errors++;
      $display("FAIL %s got lat=%0d %0d/%0d want lat=%0d %0d/%0d",
               name, lat, class_type, class_votes, LAT, wc, wv); end
  endtask

  task automatic test_level_hold();
    int dones, first, lat, bb, ec, ev;
    rand_arrays();
    dones = 0; first = -1;
    @(posedge clk); #1 valid_sort = 1;
    @(posedge clk); #1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done_class === 1'b1) begin dones++; if (first < 0) first = n; end
    end
    checks++; if (dones != 1 || first != LAT) begin errors++;
      $display("FAIL level_hold got %0d dones first=%0d want 1 at %0d", dones, first, LAT); end
    valid_sort = 0;
    rand_arrays();
    model(ec, ev);
    @(posedge clk); #1 valid_sort = 1;
    @(posedge clk); #1;
    wait_done(lat, bb);
    valid_sort = 0;
    checks++;
    if (lat != LAT || int'(class_type) != ec || int'(class_votes) != ev || nearest_distance !== dv[0]) begin
      errors++;
      $display("FAIL level_rearm got lat=%0d %0d/%0d d=%0d want lat=%0d %0d/%0d d=%0d",
               lat, class_type, class_votes, nearest_distance, LAT, ec, ev, dv[0]); end
  endtask

  task automatic test_busy_collision();
    int dones, first, ec, ev;
    logic [W-1:0] d0;
    for (int i = 0; i < N; i++) begin tv[i] = 6; dv[i] = W'(20 + i); end
    tv[1] = 3; tv[3] = 3;
    load_arrays();
    model(ec, ev);
    d0 = dv[0];
    start_pulse();
    dones = 0; first = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 3) begin
        for (int i = 0; i < N; i++) begin tv[i] = 1; dv[i] = W'(999); end
        load_arrays();
        valid_sort = 1;
      end
      if (n == 4) valid_sort = 0;
      if (done_class === 1'b1) begin
        dones++;
        if (first < 0) begin
          first = n;
          checks++;
          if (int'(class_type) != ec || int'(class_votes) != ev || nearest_distance !== d0) begin
            errors++;
            $display("FAIL collision_result got %0d/%0d d=%0d want %0d/%0d d=%0d",
                     class_type, class_votes, nearest_distance, ec, ev, d0); end
        end
      end
    end
    checks++; if (dones != 1 || first != LAT) begin errors++;
      $display("FAIL collision_dones got %0d first=%0d want 1 at %0d", dones, first, LAT); end
  endtask

  task automatic test_reset_abort();
    int dones, lat, bb, ec, ev;
    rand_arrays();
    start_pulse();
    for (int n = 1; n <= 6; n++) @(posedge clk);
    #1 rst = 1;
    #1;
    checks++;
    if (busy !== 1'b0 || done_class !== 1'b0 || class_type !== '0 ||
        class_votes !== '0 || nearest_distance !== '0) begin errors++;
      $display("FAIL abort_clear busy=%b done=%b %0d/%0d d=%0d want all 0",
               busy, done_class, class_type, class_votes, nearest_distance); end
    @(posedge clk); #1 rst = 0;
    dones = 0;
    for (int n = 0; n < 20; n++) begin @(posedge clk); #1; if (done_class === 1'b1) dones++; end
    checks++; if (dones != 0 || busy !== 1'b0) begin errors++;
      $display("FAIL abort_nodone got dones=%0d busy=%b want 0 0", dones, busy); end
    rand_arrays();
    model(ec, ev);
    start_pulse();
    wait_done(lat, bb);
    checks++;
    if (lat != LAT || int'(class_type) != ec || int'(class_votes) != ev) begin errors++;
      $display("FAIL abort_recover got lat=%0d %0d/%0d want lat=%0d %0d/%0d",
               lat, class_type, class_votes, LAT, ec, ev); end
  endtask

  task automatic test_random();
    int lat, bb, ec, ev;
    for (int r = 0; r < 20; r++) begin
      rand_arrays();
      model(ec, ev);
      start_pulse();
      // Scramble inputs mid-vote; only the start-edge snapshot may count.
      @(posedge clk); #1;
      type_array_sorted = TYPE_W*N'($urandom());
      distance_array_sorted = W*N'($urandom());
      wait_done(lat, bb);
      checks++;
      if (lat != LAT - 1 || bb != 0 || int'(class_type) != ec || int'(class_votes) != ev ||
          nearest_distance !== dv[0]) begin errors++;
        $display("FAIL random_%0d got lat=%0d bb=%0d %0d/%0d d=%0d want lat=%0d %0d/%0d d=%0d",
                 r, lat + 1, bb, class_type, class_votes, nearest_distance,
                 LAT, ec, ev, dv[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_class();
    test_pattern("majority", 1, 3, 1, 4, 1, 1, 3);
    test_pattern("tie", 4, 2, 4, 2, 5, 2, 2);
    test_pattern("class0", 0, 7, 0, 7, 6, 0, 2);
    test_level_hold();
    test_busy_collision();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end
endmodule
